// File: rtl/alu32_arbiter.sv
// Two requesters share one 32-bit ALU through a round-robin (or fixed-priority) arbiter.
// Optional sticky overflow flag is enabled by defining ALU32_ARBITER_STICKY_EN.

module alu32 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [2:0]  i_op,
   output logic [31:0] o_result,
   output logic [3:0]  o_flags
);

   logic [32:0] w_sum;
   logic        w_c;
   logic        w_v;

   always_comb begin
      w_sum    = 33'd0;
      w_c      = 1'b0;
      w_v      = 1'b0;
      o_result = 32'd0;
      case (i_op)
         3'b000: o_result = ~i_a;
         3'b001: o_result = ~i_b;
         3'b010: o_result = i_a & i_b;
         3'b011: o_result = i_a | i_b;
         3'b100: o_result = i_a ^ i_b;
         3'b101: o_result = ~(i_a ^ i_b);
         3'b110: begin
            w_sum    = {1'b0, i_a} + {1'b0, i_b};
            o_result = w_sum[31:0];
            w_c      = w_sum[32];
            w_v      = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
         end
         3'b111: begin
            // Subtract as A + ~B + 1 so carry means "no borrow"
            w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
            o_result = w_sum[31:0];
            w_c      = w_sum[32];
            w_v      = (i_a[31] != i_b[31]) && (w_sum[31] != i_a[31]);
         end
         default: o_result = 32'd0;
      endcase
   end

   assign o_flags = {w_c, o_result[31], (o_result == 32'd0), w_v};

endmodule

module alu32_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        reset,
`ifdef ALU32_ARBITER_STICKY_EN
   input  logic        sticky_clr,
   output logic        sticky_v,
`endif
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t      r_state;
   logic        r_last;
   logic [31:0] r_a_p0;
   logic [31:0] r_b_p0;
   logic [2:0]  r_op_p0;
   logic        r_id_p0;
   logic [31:0] r_result_p1;
   logic [3:0]  r_flags_p1;
   logic        r_id_p1;
   logic        r_vld_p1;

   logic        w_gnt0;
   logic        w_gnt1;
   logic [31:0] w_alu_result;
   logic [3:0]  w_alu_flags;

   // Grants exist only in IDLE and never during a reset cycle
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if ((r_state == S_IDLE) && !reset) begin
         if (req0_valid && req1_valid) begin
            if ((RR_EN != 0) && (r_last == 1'b0))
               w_gnt1 = 1'b1;
            else
               w_gnt0 = 1'b1;
         end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   alu32 u_alu (
      .i_a      (r_a_p0),
      .i_b      (r_b_p0),
      .i_op     (r_op_p0),
      .o_result (w_alu_result),
      .o_flags  (w_alu_flags)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_a_p0      <= 32'd0;
         r_b_p0      <= 32'd0;
         r_op_p0     <= 3'd0;
         r_id_p0     <= 1'b0;
         r_result_p1 <= 32'd0;
         r_flags_p1  <= 4'd0;
         r_id_p1     <= 1'b0;
         r_vld_p1    <= 1'b0;
      end else begin
         case (r_state)
            // p0: capture the granted requester's operands
            S_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_a_p0  <= w_gnt1 ? req1_a  : req0_a;
                  r_b_p0  <= w_gnt1 ? req1_b  : req0_b;
                  r_op_p0 <= w_gnt1 ? req1_op : req0_op;
                  r_id_p0 <= w_gnt1;
                  r_last  <= w_gnt1;
                  r_state <= S_EXEC;
               end
            end
            // p1: register ALU result and flags
            S_EXEC: begin
               r_result_p1 <= w_alu_result;
               r_flags_p1  <= w_alu_flags;
               r_id_p1     <= r_id_p0;
               r_vld_p1    <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_vld_p1 <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid  = r_vld_p1;
   assign rsp_id     = r_id_p1;
   assign rsp_result = r_result_p1;
   assign rsp_flags  = r_flags_p1;
   assign busy       = (r_state != S_IDLE);

`ifdef ALU32_ARBITER_STICKY_EN
   logic r_sticky;

   // Arithmetic overflow seen at the response handshake; set beats clear
   always_ff @(posedge clk) begin
      if (reset)
         r_sticky <= 1'b0;
      else if ((r_state == S_RESP) && rsp_ready && (r_op_p0[2:1] == 2'b11) && r_flags_p1[0])
         r_sticky <= 1'b1;
      else if (sticky_clr)
         r_sticky <= 1'b0;
   end

   assign sticky_v = r_sticky;
`endif

endmodule

// File: tb/tb_alu32_arbiter.sv
// Scoreboard bench for alu32_arbiter: directed ops push expectations, a monitor pops on each response.
`timescale 1ns/1ps
module tb_alu32_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;

   logic        fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
   logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_busy;
   logic [31:0] fp_rsp_result;
   logic [3:0]  fp_rsp_flags;

`ifdef ALU32_ARBITER_STICKY_EN
   logic sticky_clr, sticky_v, fp_sticky_v;
`endif

   alu32_arbiter #(.RR_EN(1)) u_dut (
      .clk(clk), .reset(reset),
`ifdef ALU32_ARBITER_STICKY_EN
      .sticky_clr(sticky_clr), .sticky_v(sticky_v),
`endif
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .busy(busy)
   );

   alu32_arbiter #(.RR_EN(0)) u_fp (
      .clk(clk), .reset(reset),
`ifdef ALU32_ARBITER_STICKY_EN
      .sticky_clr(1'b0), .sticky_v(fp_sticky_v),
`endif
      .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_a(32'd10), .req0_b(32'd3), .req0_op(3'b111),
      .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_a(32'd1), .req1_b(32'd1), .req1_op(3'b110),
      .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id), .rsp_result(fp_rsp_result),
      .rsp_flags(fp_rsp_flags), .busy(fp_busy)
   );

   typedef struct packed {logic id; logic [31:0] res; logic [3:0] flags;} exp_t;
   typedef struct packed {logic [31:0] a; logic [31:0] b; logic [2:0] op;} op_t;

   exp_t sb[$];
   op_t  q0[$], q1[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   fp_rsp_cnt = 0;
   logic fp_phase = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Response monitor for the round-robin DUT
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=id%0d/%h required=no_response", rsp_id, rsp_result);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_id", rsp_id, mon_e.id);
            chk("rsp_result", rsp_result, mon_e.res);
            chk("rsp_flags", rsp_flags, mon_e.flags);
         end
      end
   end

   // Fixed-priority DUT: requester 1 must never be granted
   always @(negedge clk) begin
      if (fp_phase && !reset) begin
         chk("fp_req1_ready", fp_req1_ready, 1'b0);
         if (fp_rsp_valid && fp_rsp_ready) begin
            fp_rsp_cnt++;
            chk("fp_rsp_id", fp_rsp_id, 1'b0);
            chk("fp_rsp_result", fp_rsp_result, 32'd7);
         end
      end
   end

   task automatic wait_rdy(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL timeout_req%0d actual=no_ready required=ready", n);
      end
   endtask

   task automatic do_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [31:0] ex_r, input logic [3:0] ex_f, input bit lat);
      bit ok;
      sb.push_back(exp_t'{id: n[0], res: ex_r, flags: ex_f});
      if (n == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
      else        begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
      wait_rdy(n, ok);
      @(posedge clk); #1;
      if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      if (ok && lat) begin
         chk("lat_exec_rsp_valid", rsp_valid, 1'b0);
         chk("lat_exec_busy", busy, 1'b1);
         @(posedge clk); #1;
         chk("lat_rsp_valid", rsp_valid, 1'b1);
      end
   endtask

   task automatic run_pair();
      bit h0, h1;
      if (q0.size() != 0) begin {req0_a, req0_b, req0_op} = q0.pop_front(); req0_valid = 1'b1; end
      if (q1.size() != 0) begin {req1_a, req1_b, req1_op} = q1.pop_front(); req1_valid = 1'b1; end
      for (int i = 0; i < 60 && (req0_valid || req1_valid); i++) begin
         @(negedge clk);
         chk("one_ready", req0_ready & req1_ready, 1'b0);
         h0 = req0_valid & req0_ready;
         h1 = req1_valid & req1_ready;
         @(posedge clk); #1;
         if (h0) begin
            if (q0.size() != 0) {req0_a, req0_b, req0_op} = q0.pop_front();
            else req0_valid = 1'b0;
         end
         if (h1) begin
            if (q1.size() != 0) {req1_a, req1_b, req1_op} = q1.pop_front();
            else req1_valid = 1'b0;
         end
      end
      if (req0_valid || req1_valid) begin
         checks++;
         errors++;
         $display("FAIL pair_timeout actual=pending required=all_accepted");
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
      @(posedge clk); #1;
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; fp_rsp_ready = 1'b1;
`ifdef ALU32_ARBITER_STICKY_EN
      sticky_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req0_ready", req0_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 1'b0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_flags", rsp_flags, 4'd0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      req0_valid = 1'b0;

      do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b110, 32'h8000_0000, 4'b0101, 1'b1);
      do_op(1, 32'hFFFF_FFFF, 32'h0000_0000, 3'b000, 32'h0000_0000, 4'b0010, 1'b0);
      do_op(0, 32'h0000_0000, 32'h1234_5678, 3'b001, 32'hEDCB_A987, 4'b0100, 1'b0);
      do_op(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000, 4'b0100, 1'b0);
      do_op(0, 32'h0000_000F, 32'h0000_00F0, 3'b011, 32'h0000_00FF, 4'b0000, 1'b0);
      do_op(1, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b100, 32'hF0F0_0F0F, 4'b0100, 1'b0);
      do_op(0, 32'h0000_0000, 32'h0000_0000, 3'b101, 32'hFFFF_FFFF, 4'b0100, 1'b0);
      do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'h0000_0000, 4'b1010, 1'b0);
      do_op(1, 32'd5, 32'd5, 3'b111, 32'h0000_0000, 4'b1010, 1'b1);
      drain();

      // Contention after a requester-1 grant: expect ids 0,1,0,1
      sb.push_back(exp_t'{id: 1'b0, res: 32'd7,         flags: 4'b0000});
      sb.push_back(exp_t'{id: 1'b1, res: 32'hFFFF_FFFF, flags: 4'b0100});
      sb.push_back(exp_t'{id: 1'b0, res: 32'h0000_000F, flags: 4'b0000});
      sb.push_back(exp_t'{id: 1'b1, res: 32'h0000_0101, flags: 4'b0000});
      q0.push_back(op_t'{a: 32'd3,     b: 32'd4,     op: 3'b110});
      q0.push_back(op_t'{a: 32'hFF,    b: 32'h0F,    op: 3'b010});
      q1.push_back(op_t'{a: 32'd2,     b: 32'd3,     op: 3'b111});
      q1.push_back(op_t'{a: 32'h100,   b: 32'h001,   op: 3'b011});
      fp_phase = 1'b1;
      fp_req0_valid = 1'b1;
      fp_req1_valid = 1'b1;
      run_pair();
      repeat (6) @(posedge clk);
      #1;
      fp_req0_valid = 1'b0;
      fp_req1_valid = 1'b0;
      drain();
      chk("fp_count_ge4", (fp_rsp_cnt >= 4), 1'b1);

      // Backpressure with requester 1 pending
      rsp_ready = 1'b0;
      do_op(0, 32'h0000_0010, 32'h0000_0001, 3'b111, 32'h0000_000F, 4'b1000, 1'b0);
      sb.push_back(exp_t'{id: 1'b1, res: 32'h0000_000F, flags: 4'b0000});
      req1_a = 32'hA; req1_b = 32'h5; req1_op = 3'b100; req1_valid = 1'b1;
      for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_rsp_result", rsp_result, 32'h0000_000F);
         chk("bp_rsp_flags", rsp_flags, 4'b1000);
         chk("bp_rsp_id", rsp_id, 1'b0);
         chk("bp_req0_ready", req0_ready, 1'b0);
         chk("bp_req1_ready", req1_ready, 1'b0);
         chk("bp_busy", busy, 1'b1);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", rsp_valid, 1'b0);
      chk("bp_release_busy", busy, 1'b0);
      chk("bp_release_req1_ready", req1_ready, 1'b1);
      @(posedge clk); #1;
      chk("bp_accept_busy", busy, 1'b1);
      req1_valid = 1'b0;
      drain();

      // Reset during EXEC discards the operation
      req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_op = 3'b010; req0_valid = 1'b1;
      begin
         bit ok;
         wait_rdy(0, ok);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      chk("mid_exec_busy", busy, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_rsp_id", rsp_id, 1'b0);
      chk("mid_rst_rsp_result", rsp_result, 32'd0);
      chk("mid_rst_rsp_flags", rsp_flags, 4'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mid_rst_no_rsp", rsp_valid, 1'b0);
      end
      sb.push_back(exp_t'{id: 1'b0, res: 32'd2,         flags: 4'b0000});
      sb.push_back(exp_t'{id: 1'b1, res: 32'hFFFF_FFFF, flags: 4'b0100});
      q0.push_back(op_t'{a: 32'd1, b: 32'd1, op: 3'b110});
      q1.push_back(op_t'{a: 32'd0, b: 32'd0, op: 3'b000});
      @(posedge clk); #1;
      run_pair();
      drain();

`ifdef ALU32_ARBITER_STICKY_EN
      chk("sticky_init", sticky_v, 1'b0);
      do_op(0, 32'h8000_0000, 32'h0000_0001, 3'b111, 32'h7FFF_FFFF, 4'b1001, 1'b0);
      drain();
      chk("sticky_set", sticky_v, 1'b1);
      do_op(1, 32'd1, 32'd1, 3'b110, 32'd2, 4'b0000, 1'b0);
      drain();
      chk("sticky_hold", sticky_v, 1'b1);
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      chk("sticky_clr", sticky_v, 1'b0);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
